// File: rtl/serial_101_pkg.sv
// Definitions shared by both ends of the 101 serial link so the transmitter
// and the detector agree on the frame states and the preamble pattern.
package serial_101_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam int PRE_LEN = 3;
  localparam logic [PRE_LEN-1:0] PREAMBLE = 3'b101;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Preamble bit sent at position idx (0 = first on the line); 0 outside the preamble.
  function automatic logic preamble_bit(input int unsigned idx);
    logic [PRE_LEN-1:0] sh;
    sh = PREAMBLE >> (PRE_LEN - 1 - idx);
    return (idx < PRE_LEN) ? sh[0] : 1'b0;
  endfunction

endpackage

// File: rtl/serial_101_framer_tx_bit_tick_gen.sv
// Bit-period divider: bit_end marks the last clk of each BIT_DIV-clk serial bit.
// Cleared on accept so every frame starts at the beginning of a bit period.
module bit_tick_gen #(
  parameter int BIT_DIV = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic bit_end
);

  localparam int CNT_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;

  logic [CNT_W-1:0] div_cnt_reg;

  assign bit_end = (div_cnt_reg == CNT_W'(BIT_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_reg <= '0;
    end else if (clear || bit_end) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serial_101_framer_tx.sv
// Serial frame transmitter: accepts a word on valid/ready and sends
// preamble 1,0,1, the payload MSB first, then GAP_BITS zeros on x.
module serial_101_framer_tx
  import serial_101_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int BIT_DIV  = 1,
  parameter int GAP_BITS = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              x,
  output logic              x_strobe,
  output logic              busy
);

  localparam int IDX_W = $clog2(max3(PRE_LEN, DATA_W, GAP_BITS) + 1);

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  bit_idx_reg, bit_idx_next;
  logic [DATA_W-1:0] data_sr_reg, data_sr_next;
  logic              x_reg, x_next;
  logic              x_strobe_reg, x_strobe_next;
  logic              ready_armed_reg;
  logic              bit_end;
  logic              accept;

  assign data_ready = (state_reg == IDLE) && ready_armed_reg;
  assign busy       = (state_reg != IDLE);
  assign accept     = data_valid && data_ready;
  assign x          = x_reg;
  assign x_strobe   = x_strobe_reg;

  bit_tick_gen #(.BIT_DIV(BIT_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (accept),
    .bit_end (bit_end)
  );

  // Holds data_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ready_armed_reg <= 1'b0;
    else          ready_armed_reg <= 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      bit_idx_reg  <= '0;
      data_sr_reg  <= '0;
      x_reg        <= 1'b0;
      x_strobe_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_idx_reg  <= bit_idx_next;
      data_sr_reg  <= data_sr_next;
      x_reg        <= x_next;
      x_strobe_reg <= x_strobe_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_idx_next = bit_idx_reg;
    data_sr_next = data_sr_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next   = PRE;
          bit_idx_next = '0;
          data_sr_next = data_in;
        end
      end
      PRE: begin
        if (bit_end) begin
          if (bit_idx_reg == IDX_W'(PRE_LEN - 1)) begin
            state_next   = DATA;
            bit_idx_next = '0;
          end else begin
            bit_idx_next = bit_idx_reg + IDX_W'(1);
          end
        end
      end
      DATA: begin
        if (bit_end) begin
          data_sr_next = data_sr_reg << 1;
          if (bit_idx_reg == IDX_W'(DATA_W - 1)) begin
            state_next   = (GAP_BITS == 0) ? IDLE : GAP;
            bit_idx_next = '0;
          end else begin
            bit_idx_next = bit_idx_reg + IDX_W'(1);
          end
        end
      end
      default: begin
        if (bit_end) begin
          if (bit_idx_reg == IDX_W'(GAP_BITS - 1)) begin
            state_next   = IDLE;
            bit_idx_next = '0;
          end else begin
            bit_idx_next = bit_idx_reg + IDX_W'(1);
          end
        end
      end
    endcase
  end

  // x and x_strobe are decoded from the next state so the registered outputs
  // line up with the state they describe; a bit starts on accept or after bit_end.
  always_comb begin
    x_next        = 1'b0;
    x_strobe_next = 1'b0;
    case (state_next)
      PRE: begin
        x_next        = preamble_bit(int'(bit_idx_next));
        x_strobe_next = accept || bit_end;
      end
      DATA: begin
        x_next        = data_sr_next[DATA_W-1];
        x_strobe_next = bit_end;
      end
      default: begin
        x_next        = 1'b0;
        x_strobe_next = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_101_framer_tx.sv
// Directed + random bench for serial_101_framer_tx: frames are predicted from
// the bit-order rules and checked clk by clk, with a 101 detector on the line.
module tb_serial_101_framer_tx;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] d1_data = 8'h00;
  logic       d1_valid = 1'b0;
  logic       d1_ready, d1_x, d1_strobe, d1_busy;
  logic [7:0] d3_data = 8'h00;
  logic       d3_valid = 1'b0;
  logic       d3_ready, d3_x, d3_strobe, d3_busy;

  int total = 0;
  int bad = 0;
  logic [2:0] hist = 3'b000;
  logic       y_seen = 1'b0;

  always #5 clk = ~clk;

  serial_101_framer_tx #(.DATA_W(8), .BIT_DIV(1), .GAP_BITS(2)) dut (
    .clk(clk), .reset_n(reset_n), .data_in(d1_data), .data_valid(d1_valid),
    .data_ready(d1_ready), .x(d1_x), .x_strobe(d1_strobe), .busy(d1_busy)
  );

  serial_101_framer_tx #(.DATA_W(8), .BIT_DIV(3), .GAP_BITS(2)) dut3 (
    .clk(clk), .reset_n(reset_n), .data_in(d3_data), .data_valid(d3_valid),
    .data_ready(d3_ready), .x(d3_x), .x_strobe(d3_strobe), .busy(d3_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Bit idx of a frame: 1,0,1 then word MSB first, then zeros.
  function automatic logic ref_bit(input logic [7:0] w, input int idx);
    logic [7:0] tmp;
    if (idx < 3) return (idx != 1);
    if (idx < 11) begin
      tmp = w >> (10 - idx);
      return tmp[0];
    end
    return 1'b0;
  endfunction

  // One clk; the loopback 101 detector watches the BIT_DIV=1 line.
  task automatic tick();
    @(posedge clk);
    #1;
    hist = {hist[1:0], d1_x};
    if (hist == 3'b101) y_seen = 1'b1;
  endtask

  task automatic send1(input logic [7:0] w, input bit keep, input logic [7:0] next_w,
                       input int pulse_at, input string tag);
    logic [7:0] cap = 8'h00;
    d1_data  = w;
    d1_valid = 1'b1;
    y_seen   = 1'b0;
    for (int c = 0; c < 13; c++) begin
      tick();
      if (c == 0) begin
        d1_data = next_w;
        if (!keep) d1_valid = 1'b0;
      end
      if (c == pulse_at) begin
        d1_valid = 1'b1;
        d1_data  = 8'h3C;
      end
      if (c == pulse_at + 1) d1_valid = 1'b0;
      chk({tag, " x"}, 32'(d1_x), 32'(ref_bit(w, c)));
      chk({tag, " strobe"}, 32'(d1_strobe), 32'(c < 11));
      chk({tag, " busy"}, 32'(d1_busy), 32'd1);
      chk({tag, " ready"}, 32'(d1_ready), 32'd0);
      if (d1_strobe && c >= 3) cap = {cap[6:0], d1_x};
    end
    tick();
    chk({tag, " idle x"}, 32'(d1_x), 32'd0);
    chk({tag, " idle ready"}, 32'(d1_ready), 32'd1);
    chk({tag, " idle busy"}, 32'(d1_busy), 32'd0);
    chk({tag, " detector y"}, 32'(y_seen), 32'd1);
    chk({tag, " payload"}, 32'(cap), 32'(w));
    $display("frame %s word=%02h keep=%0d", tag, w, keep);
  endtask

  initial begin
    logic [7:0] w, nxt;
    int scount, bcount;
    bit k;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst x", 32'(d1_x), 32'd0);
    chk("rst strobe", 32'(d1_strobe), 32'd0);
    chk("rst busy", 32'(d1_busy), 32'd0);
    chk("rst ready", 32'(d1_ready), 32'd0);
    reset_n = 1'b1;
    chk("release ready pre-edge", 32'(d1_ready), 32'd0);
    tick();
    chk("release ready", 32'(d1_ready), 32'd1);
    chk("release ready div3", 32'(d3_ready), 32'd1);

    // Single frame, fixed payload
    send1(8'hA5, 1'b0, 8'($urandom), -1, "t1");

    // Held valid: two frames with a single idle clk between them
    send1(8'h00, 1'b1, 8'h81, -1, "t3a");
    send1(8'h81, 1'b0, 8'($urandom), -1, "t3b");

    // valid pulsed mid-frame must be ignored
    send1(8'($urandom), 1'b0, 8'($urandom), 4, "t4");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4 no 2nd frame busy", 32'(d1_busy), 32'd0);
      chk("t4 no 2nd frame x", 32'(d1_x), 32'd0);
    end

    // BIT_DIV=3 timing
    w = 8'hFF;
    d3_data = w;
    d3_valid = 1'b1;
    scount = 0;
    bcount = 0;
    for (int c = 0; c < 39; c++) begin
      tick();
      if (c == 0) d3_valid = 1'b0;
      chk("t2 x", 32'(d3_x), 32'(ref_bit(w, c / 3)));
      chk("t2 strobe", 32'(d3_strobe), 32'((c % 3 == 0) && (c / 3 < 11)));
      if (d3_strobe) scount++;
      if (d3_busy) bcount++;
    end
    tick();
    chk("t2 strobe count", 32'(scount), 32'd11);
    chk("t2 busy clks", 32'(bcount), 32'd39);
    chk("t2 end busy", 32'(d3_busy), 32'd0);
    chk("t2 end ready", 32'(d3_ready), 32'd1);
    $display("frame t2 word=%02h div=3", w);

    // Reset in the middle of a frame
    d1_data = 8'($urandom);
    d1_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c == 0) d1_valid = 1'b0;
    end
    chk("t5 busy before reset", 32'(d1_busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5 async x", 32'(d1_x), 32'd0);
    chk("t5 async busy", 32'(d1_busy), 32'd0);
    chk("t5 async ready", 32'(d1_ready), 32'd0);
    tick();
    reset_n = 1'b1;
    chk("t5 ready pre-edge", 32'(d1_ready), 32'd0);
    tick();
    chk("t5 ready after release", 32'(d1_ready), 32'd1);
    chk("t5 x after release", 32'(d1_x), 32'd0);
    send1(8'($urandom), 1'b0, 8'($urandom), -1, "t5");

    // Random words over the loopback link
    w = 8'($urandom);
    for (int i = 0; i < 20; i++) begin
      nxt = 8'($urandom);
      k = (i < 19) ? 1'($urandom_range(0, 1)) : 1'b0;
      send1(w, k, nxt, -1, "t6");
      w = nxt;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
